gray_stim_checker: RTL

Parametrised self-checking stimulus sequencer for combinational wire/gate test blocks. It steps a WIDTH-bit input bus through a reflected Gray-code walk, returning to all-zero, and holds each vector for HOLD clock cycles. It samples the device-under-test outputs against an expected-value bus at the end of every hold window and reports error count, first failing step and pass/fail. It sits beside a DUT in lab benches and on-board self-test, replacing hand-written fixed-delay stimulus sequences.

---
 rtl/gray_stim_checker.sv | 111 +++++++++++
 1 files changed

// File: rtl/gray_stim_checker.sv
// Gray-code stimulus sequencer: walks a WIDTH-bit bus through a reflected Gray
// code back to zero, holds each vector HOLD cycles and checks the DUT response.
module gray_stim_checker #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned OUT_W = 2,
  parameter int unsigned HOLD  = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [OUT_W-1:0] dut_out,
  input  logic [OUT_W-1:0] exp_out,
  output logic [WIDTH-1:0] stim,
  output logic [WIDTH:0]   step,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [WIDTH:0]   first_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH:0] LAST_STEP = {1'b1, {WIDTH{1'b0}}};
  localparam logic [15:0]    HOLD_LAST = 16'(HOLD - 1);

  function automatic logic [WIDTH-1:0] gray(input logic [WIDTH-1:0] g);
    return g ^ (g >> 1);
  endfunction

  state_t           state_q;
  logic [WIDTH:0]   step_q;
  logic [WIDTH-1:0] stim_q;
  logic [15:0]      hold_q;
  logic [15:0]      err_q;
  logic [WIDTH:0]   first_q;

  logic [WIDTH:0]   step_d;
  logic [WIDTH-1:0] stim_d;
  logic [15:0]      err_d;
  logic             mismatch;

  always_comb begin
    step_d   = step_q + 1'b1;
    // stim for the next step wraps to zero once step reaches 2^WIDTH
    stim_d   = gray(step_d[WIDTH-1:0]);
    err_d    = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
    mismatch = (dut_out != exp_out);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      stim_q  <= '0;
      hold_q  <= '0;
      err_q   <= '0;
      first_q <= '1;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            step_q  <= '0;
            stim_q  <= '0;
            hold_q  <= '0;
            err_q   <= '0;
            first_q <= '1;
          end
        end
        RUN: begin
          if (abort) begin
            state_q <= IDLE;
            step_q  <= '0;
            stim_q  <= '0;
            hold_q  <= '0;
          end else if (hold_q == HOLD_LAST) begin
            hold_q <= '0;
            if (mismatch) begin
              err_q <= err_d;
              if (first_q == '1) first_q <= step_q;
            end
            if (step_q == LAST_STEP) begin
              state_q <= DONE;
            end else begin
              step_q <= step_d;
              stim_q <= stim_d;
            end
          end else begin
            hold_q <= hold_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stim      = stim_q;
  assign step      = step_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign pass      = (state_q == DONE) && (err_q == 16'd0);
  assign err_count = err_q;
  assign first_err = first_q;

endmodule
